// File: rtl/img_stream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : img_stream_loader
//  Description : Upstream feeder for the 121-64-10 TCB MNIST net. Collects an
//                8-bit raster pixel stream into a flat frame vector, pulses
//                valid_top, waits for ready_top and returns the prediction
//                with a one-cycle result strobe.
//                Optional macro IMG_TIMEOUT_EN adds a WAIT-state watchdog
//                that returns 32'hFFFF_FFFF after TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_stream_loader #(
   parameter int NPIX    = 121,
   parameter int PW      = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PW-1:0]        pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic [NPIX*PW-1:0]   img_source,
   output logic                 valid_top,
   input  logic                 ready_top,
   input  logic [31:0]          number,
   output logic [31:0]          result,
   output logic                 result_valid,
   output logic                 busy
);

   localparam int            CW     = $clog2(NPIX);
   localparam logic [CW-1:0] C_LAST = CW'(NPIX - 1);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_FIRE = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CW-1:0]        r_cnt;
   logic [NPIX*PW-1:0]   r_img;
   logic [31:0]          r_result;
   logic                 r_result_valid;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_ready_hit;
   logic                 w_timeout;

   assign w_accept    = pix_valid && (r_state == S_LOAD);
   assign w_last      = (r_cnt == C_LAST);
   assign w_ready_hit = ready_top && (r_state == S_WAIT);

`ifdef IMG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_wait_cnt;

   // Watchdog: cleared while entering WAIT (in FIRE), counts each WAIT cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_FIRE) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Expires on the TIMEOUT-th WAIT cycle so the strobe lands TIMEOUT cycles after entry
   assign w_timeout = (r_state == S_WAIT) && !ready_top &&
                      (r_wait_cnt == TW'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
   assign w_timeout        = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_next    = r_state;
      pix_ready = 1'b0;
      valid_top = 1'b0;
      busy      = 1'b0;
      case (r_state)
         S_LOAD: begin
            pix_ready = 1'b1;
            if (w_accept && w_last) begin
               w_next = S_FIRE;
            end
         end
         S_FIRE: begin
            valid_top = 1'b1;
            busy      = 1'b1;
            w_next    = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (ready_top || w_timeout) begin
               w_next = S_LOAD;
            end
         end
         default: begin
            w_next = S_LOAD;
         end
      endcase
   end

   // Pixel slot counter, returns to zero after the last pixel of a frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Frame buffer: only the addressed slot is written, and only in LOAD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_img <= '0;
      end else begin
         for (int k = 0; k < NPIX; k++) begin
            if (w_accept && (r_cnt == CW'(k))) begin
               r_img[k*PW +: PW] <= pix_in;
            end
         end
      end
   end

   // Prediction capture and one-cycle result strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (w_ready_hit) begin
            r_result       <= number;
            r_result_valid <= 1'b1;
         end else if (w_timeout) begin
            r_result       <= 32'hFFFF_FFFF;
            r_result_valid <= 1'b1;
         end
      end
   end

   assign img_source   = r_img;
   assign result       = r_result;
   assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_img_stream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_img_stream_loader
//  Description : Scoreboard bench for img_stream_loader. Driver pushes the
//                expected frame and prediction; a monitor pops and compares
//                when valid_top / result_valid appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_stream_loader;

   localparam int NPIX    = 121;
   localparam int PW      = 8;
   localparam int TIMEOUT = 16;

   typedef logic [NPIX*PW-1:0] img_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   img_t          img_source;
   logic          valid_top;
   logic          ready_top = 1'b0;
   logic [31:0]   number = '0;
   logic [31:0]   result;
   logic          result_valid;
   logic          busy;

   img_stream_loader #(.NPIX(NPIX), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .img_source(img_source), .valid_top(valid_top),
      .ready_top(ready_top), .number(number), .result(result),
      .result_valid(result_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   img_t        q_frame[$];
   logic [31:0] q_res[$];
   logic [7:0]  px [NPIX];

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_img(input string nm, input img_t act, input img_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: event not expected/seen at %0t", nm, $time);
   endtask

   // Reference frame: pixel k sits in byte k of the flat vector
   function automatic img_t frame_of_px();
      img_t f;
      for (int k = 0; k < NPIX; k++) f[k*PW +: PW] = px[k];
      return f;
   endfunction

   // Monitor: pops expectations when the DUT presents outputs
   logic prev_vt = 1'b0;
   logic prev_rv = 1'b0;
   img_t snap    = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_vt = 1'b0;
         prev_rv = 1'b0;
      end else begin
         if (valid_top) begin
            check32("valid_top_single", {31'd0, prev_vt}, 32'd0);
            if (q_frame.size() == 0) fail_now("valid_top_unexpected");
            else check_img("frame", img_source, q_frame.pop_front());
            snap = img_source;
         end else if (busy) begin
            check_img("img_stable_wait", img_source, snap);
            check32("pix_ready_busy", {31'd0, pix_ready}, 32'd0);
         end
         if (result_valid) begin
            check32("result_valid_single", {31'd0, prev_rv}, 32'd0);
            if (q_res.size() == 0) fail_now("result_valid_unexpected");
            else check32("result", result, q_res.pop_front());
         end
         prev_vt = valid_top;
         prev_rv = result_valid;
      end
   end

   // Offer one pixel until accepted (called and returns on a negedge)
   task automatic send_pix(input logic [7:0] p);
      int   n;
      logic acc;
      pix_valid = 1'b1;
      pix_in    = p;
      n = 0;
      do begin
         acc = pix_ready;
         @(posedge clk);
         @(negedge clk);
         n++;
      end while (!acc && n < 300);
      if (!acc) fail_now("pix_accept_timeout");
      pix_valid = 1'b0;
   endtask

   // Full frame from px[], random gaps up to maxgap; ends on the FIRE negedge
   task automatic send_frame(input int maxgap);
      q_frame.push_back(frame_of_px());
      for (int k = 0; k < NPIX; k++) begin
         repeat ($urandom_range(0, maxgap)) @(negedge clk);
         send_pix(px[k]);
      end
      check32("valid_top_after_last", {31'd0, valid_top}, 32'd1);
      check32("busy_in_fire", {31'd0, busy}, 32'd1);
   endtask

   // Return a prediction after 'delay' WAIT cycles (delay >= 1)
   task automatic respond(input logic [31:0] num, input int delay);
      repeat (delay) @(negedge clk);
      number    = num;
      ready_top = 1'b1;
      q_res.push_back(num);
      @(negedge clk);
      ready_top = 1'b0;
      check32("pix_ready_after_result", {31'd0, pix_ready}, 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_img("reset_img", img_source, '0);
      check32("reset_result", result, 32'd0);
      check32("reset_result_valid", {31'd0, result_valid}, 32'd0);
      check32("reset_valid_top", {31'd0, valid_top}, 32'd0);
      check32("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check32("pix_ready_after_reset", {31'd0, pix_ready}, 32'd1);

      // Ramp frame back-to-back, then prediction 7
      for (int k = 0; k < NPIX; k++) px[k] = 8'(k);
      send_frame(0);
      respond(32'd7, 3);

      // Same ramp with 0-3 cycle gaps
      send_frame(3);
      respond($urandom, $urandom_range(1, 5));

      // Random frames
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < NPIX; k++) px[k] = 8'($urandom);
         send_frame(2);
         respond($urandom, $urandom_range(1, 8));
      end

      // Abort after 50 accepts, then an all-0xAA frame
      for (int k = 0; k < 50; k++) send_pix(8'($urandom));
      rst = 1'b1;
      #1;
      check_img("abort_img_cleared", img_source, '0);
      check32("abort_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NPIX; k++) px[k] = 8'hAA;
      send_frame(1);
      respond(32'd3, 2);

      // pix_valid held through FIRE/WAIT, ready_top during FIRE ignored
      for (int k = 0; k < NPIX; k++) px[k] = 8'($urandom);
      send_frame(0);
      pix_valid = 1'b1;
      pix_in    = 8'h55;
      ready_top = 1'b1;
      @(negedge clk);
      ready_top = 1'b0;
      check32("ready_in_fire_ignored_busy", {31'd0, busy}, 32'd1);
      check32("ready_in_fire_no_result", {31'd0, result_valid}, 32'd0);
      repeat (5) @(negedge clk);
      pix_valid = 1'b0;
      respond(32'd9, 1);

      // Next frame proves no held 0x55 slipped in
      for (int k = 0; k < NPIX; k++) px[k] = 8'($urandom);
      send_frame(1);
      respond($urandom, 2);

      // Watchdog / no-response behaviour
      for (int k = 0; k < NPIX; k++) px[k] = 8'($urandom);
      send_frame(0);
`ifdef IMG_TIMEOUT_EN
      q_res.push_back(32'hFFFF_FFFF);
      for (int i = 1; i <= TIMEOUT + 1; i++) begin
         @(negedge clk);
         check32("timeout_strobe_timing", {31'd0, result_valid}, {31'd0, (i == TIMEOUT + 1)});
      end
`else
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check32("no_timeout_no_result", {31'd0, result_valid}, 32'd0);
      end
      check32("no_timeout_still_busy", {31'd0, busy}, 32'd1);
`endif

      check32("frames_outstanding", q_frame.size(), 32'd0);
      check32("results_outstanding", q_res.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound
   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
